// File: rtl/ysyx_23060096_rf_writeback.sv
// Register-file write-port merger: ALU results plus buffered LSU load results drive
// one registered write port. x0 writes are suppressed and in-flight destinations are exported.
module ysyx_23060096_rf_writeback #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    output logic                         w_en,
    output logic [ADDR_WIDTH-1:0]        waddr,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic [(1<<ADDR_WIDTH)-1:0]   pend_mask
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, occupancy;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [CNT_W-1:0]      starve_cnt;
    logic                  empty, full, force_drain;
    logic                  alu_win, pop, push, win_valid;
    logic [ADDR_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] win_data;

    // Handshakes: a beat transfers on a cycle where valid && ready; the producer
    // keeps valid and payload stable until that cycle. Ready never looks at valid.
    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign rd_idx      = rd_ptr[IDX_W-1:0];
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign occupancy   = wr_ptr - rd_ptr;
    assign force_drain = (starve_cnt >= CNT_W'(STARVE_LIMIT)) && !empty;

    assign alu_ready = !force_drain;
    assign lsu_ready = !full;
    assign alu_win   = alu_valid && alu_ready;
    assign pop       = !alu_win && !empty;
    assign push      = lsu_valid && lsu_ready;
    assign win_valid = alu_win || pop;

    always_comb begin
        win_rd   = alu_rd;
        win_data = alu_data;
        if (!alu_win) begin
            win_rd   = fifo_rd[rd_idx];
            win_data = fifo_data[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_idx]   <= lsu_rd;
            fifo_data[wr_idx] <= lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            w_en       <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            // Counts cycles the head waits behind the ALU; saturates at the limit.
            if (empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt < CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (win_valid) begin
                waddr <= win_rd;
                wdata <= win_data;
                w_en  <= (win_rd != '0);
            end else begin
                w_en  <= 1'b0;
            end
        end
    end

    // Destinations still owed to the register file: queued loads plus the output stage.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (PTR_W'(i) < occupancy)
                pend_mask[fifo_rd[rd_idx + IDX_W'(i)]] = 1'b1;
        end
        if (w_en)
            pend_mask[waddr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_ysyx_23060096_rf_writeback.sv
// Bench for ysyx_23060096_rf_writeback: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_ysyx_23060096_rf_writeback;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;
  localparam int NREG   = 1 << AW;
  localparam int EXP_W  = 32 + 1 + AW + DW;
  localparam int COMB_W = 32 + 2 + NREG;

  logic            clk;
  logic            rstn;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            lsu_valid, lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [DW-1:0]   lsu_data;
  logic            w_en;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [NREG-1:0] pend_mask;

  ysyx_23060096_rf_writeback #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .w_en(w_en), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0]  exp_q[$];   // {cycle, w_en, waddr, wdata} expected in that cycle
  logic [COMB_W-1:0] comb_q[$];  // {cycle, alu_ready, lsu_ready, pend_mask}

  // Reference model: the load buffer as a plain queue of {rd, data}
  logic [AW+DW-1:0] m_fifo[$];
  int               m_starve = 0;
  bit               m_out_v  = 0;
  logic [AW-1:0]    m_out_rd = '0;
  bit               alu_hold = 0;
  bit               lsu_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_eval();
    int               sz;
    bit               frc, e_ar, e_lr, wv, en, popped;
    logic [NREG-1:0]  pend;
    logic [AW+DW-1:0] ent;
    logic [AW-1:0]    wrd;
    logic [DW-1:0]    wd;
    sz   = m_fifo.size();
    frc  = (m_starve >= LIMIT) && (sz > 0);
    e_ar = !frc;
    e_lr = (sz < DEPTH);
    pend = '0;
    for (int k = 0; k < sz; k++) begin
      ent = m_fifo[k];
      pend[ent[AW+DW-1:DW]] = 1'b1;
    end
    if (m_out_v) pend[m_out_rd] = 1'b1;
    pend[0] = 1'b0;
    comb_q.push_back({32'(cyc), e_ar, e_lr, pend});

    wv = 0; popped = 0; wrd = '0; wd = '0;
    if (alu_valid && e_ar) begin
      wv = 1; wrd = alu_rd; wd = alu_data;
    end else if (sz > 0) begin
      ent = m_fifo.pop_front();
      wrd = ent[AW+DW-1:DW]; wd = ent[DW-1:0];
      wv = 1; popped = 1;
    end
    en = wv && (wrd != '0);
    exp_q.push_back({32'(cyc + 1), en, en ? wrd : AW'(0), en ? wd : DW'(0)});
    m_out_v  = en;
    m_out_rd = wrd;

    if (sz == 0 || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (lsu_valid && e_lr) m_fifo.push_back({lsu_rd, lsu_data});
    alu_hold = alu_valid && !e_ar;
    lsu_hold = lsu_valid && !e_lr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                      input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat);
    @(posedge clk); #1;
    if (!alu_hold) begin alu_valid = av; alu_rd = ard; alu_data = adat; end
    if (!lsu_hold) begin lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat; end
    model_eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic alu_only(input int n);
    for (int i = 0; i < n; i++)
      step(1, AW'($urandom_range(1, NREG - 1)), $urandom, 0, '0, '0);
  endtask

  // Asserts reset in the middle of a cycle and checks outputs before any clock edge.
  task automatic do_reset();
    @(posedge clk); #3;
    rstn = 1'b0;
    alu_valid = 0; lsu_valid = 0;
    alu_hold = 0; lsu_hold = 0;
    #1;
    check("rst_w_en", 64'(w_en), 64'(0));
    check("rst_waddr", 64'(waddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_pend_mask", 64'(pend_mask), 64'(0));
    check("rst_lsu_ready", 64'(lsu_ready), 64'(1));
    check("rst_alu_ready", 64'(alu_ready), 64'(1));
    m_fifo.delete();
    m_starve = 0; m_out_v = 0;
    exp_q.delete(); comb_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [COMB_W-1:0] c_rec;
  logic [EXP_W-1:0]  e_rec;
  int                rec_cyc;

  always @(negedge clk) begin
    if (rstn) begin
      while (comb_q.size() > 0) begin
        c_rec   = comb_q[0];
        rec_cyc = int'(c_rec[COMB_W-1 -: 32]);
        if (rec_cyc > cyc) break;
        void'(comb_q.pop_front());
        if (rec_cyc < cyc) check("comb_stale", 64'(rec_cyc), 64'(cyc));
        else begin
          check("alu_ready", 64'(alu_ready), 64'(c_rec[NREG+1]));
          check("lsu_ready", 64'(lsu_ready), 64'(c_rec[NREG]));
          check("pend_mask", 64'(pend_mask), 64'(c_rec[NREG-1:0]));
        end
      end
      while (exp_q.size() > 0) begin
        e_rec   = exp_q[0];
        rec_cyc = int'(e_rec[EXP_W-1 -: 32]);
        if (rec_cyc > cyc) break;
        void'(exp_q.pop_front());
        if (rec_cyc < cyc) check("write_stale", 64'(rec_cyc), 64'(cyc));
        else begin
          check("w_en", 64'(w_en), 64'(e_rec[AW+DW]));
          if (e_rec[AW+DW]) begin
            check("waddr", 64'(waddr), 64'(e_rec[AW+DW-1:DW]));
            check("wdata", 64'(wdata), 64'(e_rec[DW-1:0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    do_reset();

    // single ALU write
    step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    idle(3);

    // x0 suppression on both paths
    step(1, 5'd0, 32'h0BAD_0BAD, 0, '0, '0);
    idle(1);
    step(0, '0, '0, 1, 5'd0, 32'h1234);
    idle(3);

    // load path and pending mask
    step(0, '0, '0, 1, 5'd7, 32'hA5A5A5A5);
    idle(4);

    // starvation: one load behind continuous ALU traffic
    step(1, 5'd3, 32'h1111_0003, 1, 5'd9, 32'h9999_0009);
    alu_only(8);
    idle(3);

    // full FIFO and backpressure on a third load
    step(1, 5'd4, 32'h4444_0004, 1, 5'd10, 32'h1010_1010);
    step(1, 5'd6, 32'h6666_0006, 1, 5'd11, 32'h1111_1111);
    step(1, 5'd8, 32'h8888_0008, 1, 5'd12, 32'h1212_1212);
    alu_only(15);
    idle(3);

    // reset with two loads queued
    step(1, 5'd13, 32'h1313_1313, 1, 5'd14, 32'h1414_1414);
    step(1, 5'd15, 32'h1515_1515, 1, 5'd16, 32'h1616_1616);
    do_reset();
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60,
           ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1)),
           $urandom,
           $urandom_range(0, 99) < 40,
           ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1)),
           $urandom);
    end
    idle(6);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("comb_q_drained", 64'(comb_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
